argmax_classifier: RTL and testbench
====================================

# argmax_classifier

Sequential output-stage classifier for the digit network. It consumes the CLASS_COUNT ReLU outputs of the final neuron layer and scans them one per clock to find the winning class. It presents the digit index, its score and a no-detect flag to the display/UART logic over a valid/ready handshake.

## Interface
Parameters:
- CLASS_COUNT, 10, number of output neurons/classes (≥2)
- DATA_W, 32, width of each neuron result

Local: IDX_W = $clog2(CLASS_COUNT).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- scores  in  [DATA_W-1:0] x CLASS_COUNT  final-layer neuron results (unsigned, ReLU'd)
- in_valid  in  1  scores valid
- in_ready  out  1  block can accept a score vector
- class_idx  out  IDX_W  winning class index
- class_score  out  DATA_W  winning score
- no_detect  out  1  winning score is zero
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result

## Operation
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, capture all scores into an internal register array.
  - Clear best_idx=0, best_score=0, scan counter=0.
  - Go to SCAN.
- SCAN:
  - Each cycle compare captured score[cnt] against best_score, unsigned, strictly greater.
  - If greater, update best_idx=cnt and best_score=score[cnt].
  - Increment cnt.
  - After cnt=CLASS_COUNT-1 is evaluated, go to DONE.
  - Upstream may change scores or in_valid freely once captured.
- DONE:
  - out_valid=1.
  - class_idx=best_idx, class_score=best_score, no_detect=(best_score==0).
  - On out_valid&&out_ready, return to IDLE.
- Ties: the lowest index wins, because the compare is strict.
- All-zero vector: class_idx=0, class_score=0, no_detect=1.
- Scores are unsigned; an MSB-set value is a large positive.
- in_ready=0 in SCAN and DONE. in_valid is ignored there, with no queuing.
- Counter width IDX_W; the counter never wraps past CLASS_COUNT-1.

## Timing
- Reset values:
  - state=IDLE
  - out_valid=0, class_idx=0, class_score=0, no_detect=0
  - in_ready=0 while rst is high; in_ready=1 from the first cycle after rst deasserts.
- Latency: accept on edge k; out_valid first high after edge k+CLASS_COUNT (10 cycles at default).
- All outputs are registered.
- class_idx, class_score and no_detect are held stable while out_valid&&!out_ready.
- They are undefined-but-stable (retain last value) when out_valid=0.
- Throughput with out_ready held high: one result per CLASS_COUNT+2 cycles (accept, CLASS_COUNT scan, DONE handshake, then IDLE accepts on the next edge).
- Reset mid-SCAN or in DONE aborts the result: no out_valid pulse, IDLE next cycle.
- Reset has priority over every handshake in the same cycle.
- in_valid in the same cycle as rst is ignored.

## Structure
- Shared package ann_pkg holds:
  - CLASS_COUNT and DATA_W defaults, shared with the neuron layers
  - the state enum typedef (IDLE/SCAN/DONE)
- Single module; no sub-module is needed, since the comparator and mux are inline.
- The captured score array is a plain register array; no RAM inference.

## Test plan
- Max at index 7: scores {5,9,3,0,12,1,4,200,8,7} -> class_idx=7, class_score=200, no_detect=0; out_valid rises exactly 10 edges after accept.
- Tie: indices 2 and 8 both 1000, others 10 -> class_idx=2, class_score=1000.
- All zero -> class_idx=0, class_score=0, no_detect=1.
- Unsigned check: index 4 = 32'h8000_0000, others 32'h7FFF_FFFF -> class_idx=4.
- Backpressure: out_ready low for 5 cycles in DONE -> outputs held constant, in_ready=0, a new in_valid is ignored. Raise out_ready -> IDLE, the next vector is accepted and gives the correct result.
- Reset on the 4th SCAN cycle -> out_valid never asserts, in_ready=1 the cycle after rst falls. The fresh vector {0,0,0,0,0,0,0,0,0,9} gives class_idx=9.

Source files
------------

// File: rtl/ann_pkg.sv
// Shared definitions for the digit network output stages: layer-size defaults and the
// classifier state encoding.
package ann_pkg;

   localparam int unsigned ANN_CLASS_COUNT = 10;
   localparam int unsigned ANN_DATA_W      = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } ann_state_t;

endpackage

// File: rtl/argmax_classifier.sv
// Sequential argmax over the final-layer scores: one score per clock, result after CLASS_COUNT
// cycles; in_ready is low until the result is taken, and the result holds while out_ready is low.
module argmax_classifier
   import ann_pkg::*;
#(
   parameter int unsigned CLASS_COUNT = ANN_CLASS_COUNT,
   parameter int unsigned DATA_W      = ANN_DATA_W,
   localparam int unsigned IDX_W      = $clog2(CLASS_COUNT)
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [CLASS_COUNT-1:0][DATA_W-1:0]   scores,
   input  logic                                 in_valid,
   output logic                                 in_ready,
   output logic [IDX_W-1:0]                     class_idx,
   output logic [DATA_W-1:0]                    class_score,
   output logic                                 no_detect,
   output logic                                 out_valid,
   input  logic                                 out_ready
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CLASS_COUNT - 1);

   ann_state_t          state_q, state_d;
   logic [IDX_W-1:0]    cnt_q, cnt_d;
   logic [IDX_W-1:0]    best_idx_q, best_idx_d;
   logic [DATA_W-1:0]   best_score_q, best_score_d;
   logic                in_ready_q, in_ready_d;
   logic                out_valid_q, out_valid_d;
   logic [IDX_W-1:0]    class_idx_q, class_idx_d;
   logic [DATA_W-1:0]   class_score_q, class_score_d;
   logic                no_detect_q, no_detect_d;
   logic [DATA_W-1:0]   cap_q [CLASS_COUNT];
   logic [DATA_W-1:0]   cap_d [CLASS_COUNT];

   logic                capture;
   logic [DATA_W-1:0]   cur_score;
   logic                cur_wins;
   logic                last_cnt;
   logic [IDX_W-1:0]    win_idx;
   logic [DATA_W-1:0]   win_score;

   assign capture   = (state_q == IDLE) && in_valid && in_ready_q && !rst;
   assign cur_score = cap_q[cnt_q];
   // Strict compare keeps the earliest index on ties.
   assign cur_wins  = cur_score > best_score_q;
   assign last_cnt  = (cnt_q == LAST_IDX);
   assign win_idx   = cur_wins ? cnt_q : best_idx_q;
   assign win_score = cur_wins ? cur_score : best_score_q;

   always_comb begin
      cap_d = cap_q;
      if (capture) begin
         for (int i = 0; i < int'(CLASS_COUNT); i++) begin
            cap_d[i] = scores[i];
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      best_idx_d    = best_idx_q;
      best_score_d  = best_score_q;
      in_ready_d    = in_ready_q;
      out_valid_d   = out_valid_q;
      class_idx_d   = class_idx_q;
      class_score_d = class_score_q;
      no_detect_d   = no_detect_q;

      case (state_q)
         IDLE: begin
            in_ready_d = 1'b1;
            if (capture) begin
               state_d      = SCAN;
               cnt_d        = '0;
               best_idx_d   = '0;
               best_score_d = '0;
               in_ready_d   = 1'b0;
            end
         end
         SCAN: begin
            best_idx_d   = win_idx;
            best_score_d = win_score;
            if (last_cnt) begin
               state_d       = DONE;
               out_valid_d   = 1'b1;
               class_idx_d   = win_idx;
               class_score_d = win_score;
               no_detect_d   = (win_score == '0);
            end else begin
               cnt_d = cnt_q + IDX_W'(1);
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d     = IDLE;
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
            end
         end
         default: begin
            state_d     = IDLE;
            in_ready_d  = 1'b0;
            out_valid_d = 1'b0;
         end
      endcase
   end

   // Score array carries no reset: it is always rewritten before being scanned.
   always_ff @(posedge clk) begin
      cap_q <= cap_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         best_idx_q    <= '0;
         best_score_q  <= '0;
         in_ready_q    <= 1'b0;
         out_valid_q   <= 1'b0;
         class_idx_q   <= '0;
         class_score_q <= '0;
         no_detect_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         best_idx_q    <= best_idx_d;
         best_score_q  <= best_score_d;
         in_ready_q    <= in_ready_d;
         out_valid_q   <= out_valid_d;
         class_idx_q   <= class_idx_d;
         class_score_q <= class_score_d;
         no_detect_q   <= no_detect_d;
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = out_valid_q;
   assign class_idx   = class_idx_q;
   assign class_score = class_score_q;
   assign no_detect   = no_detect_q;

endmodule

// File: tb/tb_argmax_classifier.sv
// Bench for argmax_classifier: directed vectors with literal results plus randomized vectors
// checked every cycle against a max-then-first-index reference model.
module tb_argmax_classifier;
   import ann_pkg::*;

   localparam int CC = ANN_CLASS_COUNT;
   localparam int DW = ANN_DATA_W;
   localparam int IW = $clog2(CC);

   typedef logic [CC-1:0][DW-1:0] vec_t;
   typedef struct packed {
      logic [IW-1:0] idx;
      logic [DW-1:0] score;
      logic          nd;
   } res_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   vec_t          scores = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [IW-1:0] class_idx;
   logic [DW-1:0] class_score;
   logic          no_detect;
   logic          out_valid;
   logic          out_ready;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   logic rand_rdy = 1'b0;
   logic rdy_force = 1'b1;

   logic pend = 1'b0;
   logic e_seen = 1'b0;
   res_t e_res;
   int   e_k = 0;

   argmax_classifier #(.CLASS_COUNT(CC), .DATA_W(DW)) dut (
      .clk         (clk),
      .rst         (rst),
      .scores      (scores),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .class_idx   (class_idx),
      .class_score (class_score),
      .no_detect   (no_detect),
      .out_valid   (out_valid),
      .out_ready   (out_ready)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_force;
      end
   end

   // Reference: find the maximum value, then the first index holding it.
   function automatic res_t model(input vec_t v);
      res_t          r;
      logic [DW-1:0] mx;
      mx = '0;
      for (int i = 0; i < CC; i++) if (v[i] > mx) mx = v[i];
      r.idx = '0;
      for (int i = CC - 1; i >= 0; i--) if (v[i] == mx) r.idx = IW'(i);
      r.score = mx;
      r.nd    = (mx == '0);
      return r;
   endfunction

   function automatic vec_t mk10(input logic [31:0] a0, a1, a2, a3, a4, a5, a6, a7, a8, a9);
      vec_t v;
      v[0] = a0; v[1] = a1; v[2] = a2; v[3] = a3; v[4] = a4;
      v[5] = a5; v[6] = a6; v[7] = a7; v[8] = a8; v[9] = a9;
      return v;
   endfunction

   function automatic vec_t rand_vec();
      vec_t v;
      for (int i = 0; i < CC; i++) begin
         case ($urandom_range(0, 3))
            0:       v[i] = '0;
            1:       v[i] = DW'($urandom_range(0, 7));
            2:       v[i] = DW'($urandom);
            default: v[i] = DW'(32'h8000_0000 | $urandom_range(0, 3));
         endcase
      end
      if ($urandom_range(0, 7) == 0) v = '0;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Per-cycle scoreboard: one outstanding result at most, since the block never queues.
   initial forever begin
      @(negedge clk);
      if (rst) begin
         pend = 1'b0;
      end else begin
         if (out_valid) begin
            if (!pend) begin
               chk("spurious_out_valid", out_valid, 0);
            end else begin
               chk("class_idx", class_idx, e_res.idx);
               chk("class_score", class_score, e_res.score);
               chk("no_detect", no_detect, e_res.nd);
               chk("done_in_ready", in_ready, 0);
               if (!e_seen) begin
                  chk("latency", cyc - e_k, CC);
                  e_seen = 1'b1;
               end
               if (out_ready) pend = 1'b0;
            end
         end else if (pend) begin
            chk("scan_in_ready", in_ready, 0);
            if (cyc - e_k >= CC) begin
               chk("out_valid_late", out_valid, 1);
               pend = 1'b0;
            end
         end
         if (in_valid && in_ready) begin
            chk("accept_while_busy", pend, 0);
            pend   = 1'b1;
            e_seen = 1'b0;
            e_res  = model(scores);
            e_k    = cyc + 1;
         end
      end
   end

   task automatic send(input vec_t v, output int acc_cyc);
      int t;
      bit ok;
      t = 0;
      ok = 0;
      in_valid = 1'b1;
      scores = v;
      while (!ok && t < 100) begin
         @(negedge clk);
         ok = in_ready && !rst;
         @(posedge clk);
         #1;
         t++;
      end
      acc_cyc = cyc;
      in_valid = 1'b0;
      for (int i = 0; i < CC; i++) scores[i] = DW'($urandom);
      if (!ok) chk("accept_timeout", ok, 1);
   endtask

   task automatic wait_out(output bit ok);
      int t;
      t = 0;
      ok = 0;
      while (!ok && t < 60) begin
         @(negedge clk);
         ok = out_valid;
         t++;
      end
      if (!ok) chk("out_valid_timeout", ok, 1);
   endtask

   task automatic wait_hs();
      int t;
      bit ok;
      t = 0;
      ok = out_valid && out_ready;
      while (!ok && t < 60) begin
         @(negedge clk);
         ok = out_valid && out_ready;
         t++;
      end
      if (!ok) chk("handshake_timeout", ok, 1);
      @(posedge clk);
      #1;
   endtask

   task automatic directed(input string nm, input vec_t v, input int eidx,
                           input logic [DW-1:0] es, input logic end_);
      int a;
      bit ok;
      send(v, a);
      wait_out(ok);
      if (ok) begin
         chk({nm, "_latency"}, cyc - a, 10);
         chk({nm, "_idx"}, class_idx, eidx);
         chk({nm, "_score"}, class_score, es);
         chk({nm, "_no_detect"}, no_detect, end_);
      end
      wait_hs();
   endtask

   initial begin
      vec_t v;
      int   a0, a1, a2, seen;
      bit   ok;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_class_idx", class_idx, 0);
      chk("rst_class_score", class_score, 0);
      chk("rst_no_detect", no_detect, 0);
      chk("rst_in_ready", in_ready, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("post_rst_in_ready", in_ready, 1);
      @(posedge clk);
      #1;

      directed("max7", mk10(5, 9, 3, 0, 12, 1, 4, 200, 8, 7), 7, 200, 1'b0);
      directed("tie", mk10(10, 10, 1000, 10, 10, 10, 10, 10, 1000, 10), 2, 1000, 1'b0);
      directed("zero", '0, 0, 0, 1'b1);
      for (int i = 0; i < CC; i++) v[i] = 32'h7FFF_FFFF;
      v[4] = 32'h8000_0000;
      directed("unsigned", v, 4, 32'h8000_0000, 1'b0);

      // Backpressure: result must hold and a new request must be ignored.
      rdy_force = 1'b0;
      send(mk10(3, 1, 4, 1, 5, 9, 2, 6, 5, 3), a0);
      wait_out(ok);
      scores = mk10(99, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      in_valid = 1'b1;
      repeat (5) begin
         @(negedge clk);
         chk("bp_in_ready", in_ready, 0);
         chk("bp_out_valid", out_valid, 1);
         chk("bp_idx_held", class_idx, 5);
         chk("bp_score_held", class_score, 9);
      end
      rdy_force = 1'b1;
      directed("bp_next", mk10(10, 20, 30, 40, 50, 60, 70, 80, 90, 5), 8, 90, 1'b0);

      // Reset on the 4th scan cycle aborts the result.
      send(mk10(1, 2, 3, 4, 5, 6, 7, 8, 9, 10), a0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      in_valid = 1'b1;
      scores = mk10(0, 0, 0, 0, 77, 0, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      chk("abort_in_ready_low", in_ready, 0);
      chk("abort_out_valid", out_valid, 0);
      @(negedge clk);
      chk("abort_in_ready_high", in_ready, 1);
      seen = 0;
      repeat (12) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      chk("abort_no_valid", seen, 0);
      @(posedge clk);
      #1;
      directed("fresh9", mk10(0, 0, 0, 0, 0, 0, 0, 0, 0, 9), 9, 9, 1'b0);

      // Back-to-back throughput with out_ready held high.
      send(rand_vec(), a0);
      send(rand_vec(), a1);
      send(rand_vec(), a2);
      chk("throughput_1", a1 - a0, CC + 2);
      chk("throughput_2", a2 - a1, CC + 2);
      wait_out(ok);
      wait_hs();

      rand_rdy = 1'b1;
      repeat (60) begin
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
         send(rand_vec(), a0);
      end
      rand_rdy = 1'b0;
      seen = 0;
      while (pend && seen < 100) begin
         @(posedge clk);
         seen++;
      end
      @(negedge clk);
      chk("drain", pend, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

endmodule
